// File: rtl/led_shifter.sv
// rtl/led_shifter.sv - prescaled LED pattern engine: rotate, bounce, fill/drain
module led_shifter #(
    parameter int N_LEDS   = 10,
    parameter int TICK_DIV = 12_500_000
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    output logic [N_LEDS-1:0] led_o,
    output logic              step_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [N_LEDS-1:0] LED_LSB  = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] LED_MSB  = LED_LSB << (N_LEDS - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ROTL,
        ST_ROTR,
        ST_BNC_L,
        ST_BNC_R,
        ST_FILL,
        ST_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic [1:0]        mode_q, mode_d;
    logic              step_q, step_d;
    logic              tick;

    // Candidate next patterns, all kept N_LEDS wide so no stray bits appear
    logic [N_LEDS-1:0] rotl_nxt, rotr_nxt, shl_nxt, shr_nxt, fill_nxt, drain_nxt;
    assign rotl_nxt  = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
    assign rotr_nxt  = {led_q[0], led_q[N_LEDS-1:1]};
    assign shl_nxt   = led_q << 1;
    assign shr_nxt   = led_q >> 1;
    assign fill_nxt  = {led_q[N_LEDS-2:0], 1'b1};
    assign drain_nxt = {led_q[N_LEDS-2:0], 1'b0};

    // Prescaler: counts only while enabled, holds its value while paused
    always_comb begin
        tick  = en_i && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // Step logic: on each tick either load a mode's start pattern or advance it
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        mode_d  = mode_q;
        step_d  = tick;
        if (tick) begin
            if (state_q == ST_INIT || mode_i != mode_q) begin
                mode_d = mode_i;
                case (mode_i)
                    2'd0: begin led_d = LED_LSB; state_d = ST_ROTL;  end
                    2'd1: begin led_d = LED_MSB; state_d = ST_ROTR;  end
                    2'd2: begin led_d = LED_LSB; state_d = ST_BNC_L; end
                    default: begin led_d = '0;   state_d = ST_FILL;  end
                endcase
            end else begin
                case (state_q)
                    ST_ROTL: led_d = rotl_nxt;
                    ST_ROTR: led_d = rotr_nxt;
                    ST_BNC_L: begin
                        led_d = shl_nxt;
                        if (shl_nxt[N_LEDS-1]) state_d = ST_BNC_R;
                    end
                    ST_BNC_R: begin
                        led_d = shr_nxt;
                        if (shr_nxt[0]) state_d = ST_BNC_L;
                    end
                    ST_FILL: begin
                        led_d = fill_nxt;
                        if (&fill_nxt) state_d = ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        led_d = drain_nxt;
                        if (drain_nxt == '0) state_d = ST_FILL;
                    end
                    default: state_d = ST_INIT;
                endcase
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            led_q   <= '0;
            mode_q  <= 2'd0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
        end
    end

    assign led_o  = led_q;
    assign step_o = step_q;

endmodule

// File: tb/tb_led_shifter.sv
// tb/tb_led_shifter.sv - self-checking bench for led_shifter against a pattern-index model
module tb_led_shifter;

    localparam int N  = 10;
    localparam int TD = 4;

    logic         clk_i = 1'b0;
    logic         reset_ni = 1'b0;
    logic         en_i = 1'b0;
    logic [1:0]   mode_i = 2'd0;
    logic [N-1:0] led_o;
    logic         step_o;

    int total = 0;
    int bad   = 0;

    // Reference model state: prescaler count, whether a pattern is loaded,
    // the latched mode and the index of the current pattern within its cycle
    int           m_cnt;
    bit           m_loaded;
    int           m_mode;
    int           m_k;
    logic [N-1:0] exp_led;
    logic         exp_step;

    led_shifter #(.N_LEDS(N), .TICK_DIV(TD)) dut (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .en_i    (en_i),
        .mode_i  (mode_i),
        .led_o   (led_o),
        .step_o  (step_o)
    );

    always #5 clk_i = ~clk_i;

    // Pattern shown k ticks after the start pattern of mode m was loaded
    function automatic logic [N-1:0] pat(input int m, input int k);
        int p;
        int pos;
        int full;
        full = (1 << N) - 1;
        case (m)
            0: return N'(1 << (k % N));
            1: return N'(1 << (N - 1 - (k % N)));
            2: begin
                p   = k % (2 * (N - 1));
                pos = (p < N) ? p : 2 * (N - 1) - p;
                return N'(1 << pos);
            end
            default: begin
                p = k % (2 * N);
                if (p <= N) return N'((1 << p) - 1);
                return N'((full << (p - N)) & full);
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_loaded = 0;
        m_mode   = 0;
        m_k      = 0;
        exp_led  = '0;
        exp_step = 1'b0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it
    task automatic cyc(input bit e, input int m);
        bit tk;
        en_i   = e;
        mode_i = 2'(m);
        @(posedge clk_i);
        tk = e && (m_cnt == TD - 1);
        if (e) m_cnt = tk ? 0 : m_cnt + 1;
        exp_step = tk;
        if (tk) begin
            if (!m_loaded || m != m_mode) begin
                m_loaded = 1;
                m_mode   = m;
                m_k      = 0;
            end else begin
                m_k++;
            end
            exp_led = pat(m_mode, m_k);
        end
        #1;
        check("led", led_o, exp_led);
        check("step", N'(step_o), N'(exp_step));
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge
    task automatic do_reset();
        #2;
        reset_ni = 1'b0;
        model_reset();
        #1;
        check("rst_led", led_o, '0);
        check("rst_step", N'(step_o), '0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    initial begin
        int mode;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_led", led_o, '0);
        check("rst_step", N'(step_o), '0);
        reset_ni = 1'b1;

        // Each mode from reset, long enough to wrap at least once
        for (int m = 0; m < 4; m++) begin
            do_reset();
            for (int i = 0; i < TD * (2 * N + 3); i++) cyc(1'b1, m);
        end

        // Pause while the prescaler sits at 2, then resume
        do_reset();
        for (int i = 0; i < TD * 3 + 2; i++) cyc(1'b1, 0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 0);
        for (int i = 0; i < TD * 2; i++) cyc(1'b1, 0);

        // Mode switch 0 -> 3 mid-rotation, then reset part-way through a period
        do_reset();
        for (int i = 0; i < TD * 5 + 1; i++) cyc(1'b1, 0);
        for (int i = 0; i < TD * 4 + 1; i++) cyc(1'b1, 3);
        do_reset();

        // Randomized enables and occasional mode changes
        mode = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) mode = int'($urandom_range(0, 3));
            cyc($urandom_range(0, 3) != 0, mode);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
